// File: rtl/priv_1_11_trap_sequencer.sv
// Trap/return initiator: arbitrates exceptions, interrupts and mret,
// drains the pipeline, then issues a one-cycle commit or return strobe
// together with the matching machine-mode CSR writes.
module priv_1_11_trap_sequencer #(
    parameter int CAUSE_W = 5,
    parameter int XLEN    = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ex_req,
    input  logic [CAUSE_W-1:0] ex_cause,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [XLEN-1:0]    ex_tval,
    input  logic               irq_pending,
    input  logic [CAUSE_W-1:0] irq_cause,
    input  logic [XLEN-1:0]    irq_pc,
    input  logic               mie_in,
    input  logic               mpie_in,
    input  logic               mret_req,
    input  logic               pipe_clear,
    output logic               flush_req,
    output logic               intr,
    output logic               mret,
    output logic               mepc_wen,
    output logic [XLEN-1:0]    mepc_wdata,
    output logic               mcause_wen,
    output logic               mcause_int,
    output logic [CAUSE_W-1:0] mcause_code,
    output logic               mtval_wen,
    output logic [XLEN-1:0]    mtval_wdata,
    output logic               mstatus_wen,
    output logic               mie_next,
    output logic               mpie_next,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_RET
    } state_t;

    state_t             state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic               int_q, int_d;

    // State and trap-context registers; reset aborts any sequence in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            int_q   <= int_d;
        end
    end

    // Next-state arbitration: exception > enabled interrupt > mret; the
    // trap context is captured only on leaving IDLE and frozen afterwards.
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        int_d   = int_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_req) begin
                    cause_d = ex_cause;
                    pc_d    = ex_pc;
                    tval_d  = ex_tval;
                    int_d   = 1'b0;
                    state_d = S_DRAIN;
                end else if (irq_pending && mie_in) begin
                    cause_d = irq_cause;
                    pc_d    = irq_pc;
                    tval_d  = '0;
                    int_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (mret_req) begin
                    state_d = S_RET;
                end
            end
            S_DRAIN: begin
                // pipe_clear is only looked at from inside DRAIN, so at
                // least one drain cycle is always spent.
                if (pipe_clear) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            S_RET:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode; only mie_next/mpie_next pass live status bits.
    always_comb begin
        flush_req   = 1'b0;
        intr        = 1'b0;
        mret        = 1'b0;
        mepc_wen    = 1'b0;
        mepc_wdata  = '0;
        mcause_wen  = 1'b0;
        mcause_int  = 1'b0;
        mcause_code = '0;
        mtval_wen   = 1'b0;
        mtval_wdata = '0;
        mstatus_wen = 1'b0;
        mie_next    = 1'b0;
        mpie_next   = 1'b0;
        busy        = (state_q != S_IDLE);
        unique case (state_q)
            S_DRAIN: begin
                flush_req = 1'b1;
            end
            S_COMMIT: begin
                flush_req   = 1'b1;
                intr        = 1'b1;
                mepc_wen    = 1'b1;
                mepc_wdata  = {pc_q[XLEN-1:2], 2'b00};
                mcause_wen  = 1'b1;
                mcause_int  = int_q;
                mcause_code = cause_q;
                mtval_wen   = 1'b1;
                mtval_wdata = tval_q;
                mstatus_wen = 1'b1;
                mie_next    = 1'b0;
                mpie_next   = mie_in;
            end
            S_RET: begin
                mret        = 1'b1;
                mstatus_wen = 1'b1;
                mie_next    = mpie_in;
                mpie_next   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// Scoreboard bench for the trap sequencer: stimulus pushes the expected
// commit/return record, a negedge monitor pops it whenever a strobe or
// CSR write appears.
module tb_priv_1_11_trap_sequencer;

    localparam int CAUSE_W = 5;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic            flush_req;
        logic            intr;
        logic            mret;
        logic            mepc_wen;
        logic [31:0]     mepc_wdata;
        logic            mcause_wen;
        logic            mcause_int;
        logic [4:0]      mcause_code;
        logic            mtval_wen;
        logic [31:0]     mtval_wdata;
        logic            mstatus_wen;
        logic            mie_next;
        logic            mpie_next;
    } rec_t;

    logic               CLK;
    logic               RST;
    logic               ex_req;
    logic [CAUSE_W-1:0] ex_cause;
    logic [XLEN-1:0]    ex_pc;
    logic [XLEN-1:0]    ex_tval;
    logic               irq_pending;
    logic [CAUSE_W-1:0] irq_cause;
    logic [XLEN-1:0]    irq_pc;
    logic               mie_in;
    logic               mpie_in;
    logic               mret_req;
    logic               pipe_clear;
    logic               flush_req;
    logic               intr;
    logic               mret;
    logic               mepc_wen;
    logic [XLEN-1:0]    mepc_wdata;
    logic               mcause_wen;
    logic               mcause_int;
    logic [CAUSE_W-1:0] mcause_code;
    logic               mtval_wen;
    logic [XLEN-1:0]    mtval_wdata;
    logic               mstatus_wen;
    logic               mie_next;
    logic               mpie_next;
    logic               busy;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];

    priv_1_11_trap_sequencer #(.CAUSE_W(CAUSE_W), .XLEN(XLEN)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ex_req      (ex_req),
        .ex_cause    (ex_cause),
        .ex_pc       (ex_pc),
        .ex_tval     (ex_tval),
        .irq_pending (irq_pending),
        .irq_cause   (irq_cause),
        .irq_pc      (irq_pc),
        .mie_in      (mie_in),
        .mpie_in     (mpie_in),
        .mret_req    (mret_req),
        .pipe_clear  (pipe_clear),
        .flush_req   (flush_req),
        .intr        (intr),
        .mret        (mret),
        .mepc_wen    (mepc_wen),
        .mepc_wdata  (mepc_wdata),
        .mcause_wen  (mcause_wen),
        .mcause_int  (mcause_int),
        .mcause_code (mcause_code),
        .mtval_wen   (mtval_wen),
        .mtval_wdata (mtval_wdata),
        .mstatus_wen (mstatus_wen),
        .mie_next    (mie_next),
        .mpie_next   (mpie_next),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t cur_rec();
        rec_t r;
        r.flush_req   = flush_req;
        r.intr        = intr;
        r.mret        = mret;
        r.mepc_wen    = mepc_wen;
        r.mepc_wdata  = mepc_wdata;
        r.mcause_wen  = mcause_wen;
        r.mcause_int  = mcause_int;
        r.mcause_code = mcause_code;
        r.mtval_wen   = mtval_wen;
        r.mtval_wdata = mtval_wdata;
        r.mstatus_wen = mstatus_wen;
        r.mie_next    = mie_next;
        r.mpie_next   = mpie_next;
        return r;
    endfunction

    function automatic rec_t trap_rec(input logic is_int, input logic [4:0] code,
                                      input logic [31:0] epc, input logic [31:0] tval,
                                      input logic mpie);
        rec_t r;
        r             = '0;
        r.flush_req   = 1'b1;
        r.intr        = 1'b1;
        r.mepc_wen    = 1'b1;
        r.mepc_wdata  = epc;
        r.mcause_wen  = 1'b1;
        r.mcause_int  = is_int;
        r.mcause_code = code;
        r.mtval_wen   = 1'b1;
        r.mtval_wdata = tval;
        r.mstatus_wen = 1'b1;
        r.mie_next    = 1'b0;
        r.mpie_next   = mpie;
        return r;
    endfunction

    // Monitor: any strobe or CSR write must match the oldest expected record.
    always @(negedge CLK) begin
        if (intr || mret || mepc_wen || mcause_wen || mtval_wen || mstatus_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %0h expected none", cur_rec());
            end else begin
                check("strobe_record", 128'(cur_rec()), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called one cycle into DRAIN; walks the flush window, raising
    // pipe_clear on the clear_at-th flush cycle, and returns the number of
    // cycles flush_req was observed high. Ends in the first IDLE cycle.
    task automatic run_drain(input int clear_at, input bit drop_irq, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!flush_req) return;
            n++;
            ex_req     = 1'b0;
            if (drop_irq) irq_pending = 1'b0;
            pipe_clear = (n == clear_at);
            step();
        end
        checks++;
        errors++;
        $display("FAIL drain_bound: flush_req still high after 20 cycles, expected release");
    endtask

    initial begin
        int n;
        RST = 1'b1;
        ex_req = 1'b0; ex_cause = '0; ex_pc = '0; ex_tval = '0;
        irq_pending = 1'b0; irq_cause = '0; irq_pc = '0;
        mie_in = 1'b0; mpie_in = 1'b0; mret_req = 1'b0; pipe_clear = 1'b0;
        step();
        step();
        check("reset_outputs", 128'(cur_rec()), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        RST = 1'b0;
        step();

        // Reset while draining: sequence aborted, nothing written.
        ex_req = 1'b1; ex_cause = 5'd2; ex_pc = 32'h100; ex_tval = 32'hDEAD; mie_in = 1'b1;
        step();
        check("rst_drain_entered", 128'({busy, flush_req}), 128'(2'b11));
        ex_req = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_abort_outputs", 128'(cur_rec()), 128'(0));
        check("rst_abort_busy", 128'(busy), 128'(0));
        step();
        step();
        RST = 1'b0;
        step();
        step();
        check("rst_abort_idle", 128'({busy, flush_req}), 128'(0));

        // Exception, pipe_clear on third drain cycle: four flush cycles.
        ex_req = 1'b1; ex_cause = 5'd2; ex_pc = 32'h1000; ex_tval = 32'hDEADBEEF;
        mie_in = 1'b1; mpie_in = 1'b0;
        exp_q.push_back(trap_rec(1'b0, 5'd2, 32'h1000, 32'hDEADBEEF, 1'b1));
        step();
        check("ex_no_early_intr", 128'(intr), 128'(0));
        run_drain(3, 1'b0, n);
        check("ex_flush_cycles", 128'(n), 128'(4));

        // Interrupt dropped during DRAIN still commits (back-to-back start).
        irq_pending = 1'b1; irq_cause = 5'd7; irq_pc = 32'h2004; mie_in = 1'b1;
        exp_q.push_back(trap_rec(1'b1, 5'd7, 32'h2004, 32'h0, 1'b1));
        step();
        run_drain(1, 1'b1, n);
        check("irq_flush_cycles", 128'(n), 128'(2));

        // pipe_clear already high on entry still costs a DRAIN cycle;
        // misaligned PC has its low bits cleared in mepc.
        pipe_clear = 1'b1;
        ex_req = 1'b1; ex_cause = 5'd4; ex_pc = 32'h3003; ex_tval = 32'h3003; mie_in = 1'b0;
        exp_q.push_back(trap_rec(1'b0, 5'd4, 32'h3000, 32'h3003, 1'b0));
        step();
        check("preclear_drain_state", 128'({flush_req, intr}), 128'(2'b10));
        run_drain(1, 1'b0, n);
        check("preclear_flush_cycles", 128'(n), 128'(2));
        pipe_clear = 1'b0;

        // Masked interrupt is never taken.
        irq_pending = 1'b1; irq_cause = 5'd7; mie_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("masked_irq_idle", 128'({busy, flush_req}), 128'(0));
        end
        irq_pending = 1'b0;

        // mret: one-cycle return strobe, no flush, only mstatus written.
        mret_req = 1'b1; mpie_in = 1'b1; mie_in = 1'b0;
        begin
            rec_t r;
            r = '0;
            r.mret = 1'b1; r.mstatus_wen = 1'b1; r.mie_next = 1'b1; r.mpie_next = 1'b1;
            exp_q.push_back(r);
        end
        step();
        mret_req = 1'b0;
        check("mret_latency", 128'({mret, flush_req}), 128'(2'b10));
        step();
        check("mret_single_cycle", 128'({mret, busy}), 128'(0));

        // Exception + interrupt + mret together: exception wins.
        ex_req = 1'b1; ex_cause = 5'd11; ex_pc = 32'h4000; ex_tval = 32'h44;
        irq_pending = 1'b1; irq_cause = 5'd3; irq_pc = 32'h5000;
        mret_req = 1'b1; mie_in = 1'b1; mpie_in = 1'b0;
        exp_q.push_back(trap_rec(1'b0, 5'd11, 32'h4000, 32'h44, 1'b1));
        step();
        run_drain(2, 1'b0, n);
        check("simul_flush_cycles", 128'(n), 128'(3));
        // Trap handler running with MIE cleared; mret no longer requested.
        mie_in = 1'b0; mret_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("simul_irq_masked", 128'(busy), 128'(0));
        end
        mie_in = 1'b1;
        exp_q.push_back(trap_rec(1'b1, 5'd3, 32'h5000, 32'h0, 1'b1));
        step();
        run_drain(2, 1'b1, n);
        check("deferred_irq_flush_cycles", 128'(n), 128'(3));

        step();
        step();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priv_1_11_trap_sequencer.md
Name: priv_1_11_trap_sequencer

Overview:
- Initiator side of the privileged trap/return protocol.
- Arbitrates synchronous exceptions, pending interrupts and mret requests.
- On a trap: requests a pipeline flush, waits for the pipeline to report drained, then issues the one-cycle `intr` / `mret` strobes to the PC-insertion logic and writes mepc/mcause/mtval/mstatus in the same cycle.

Parameters:
- CAUSE_W, 5: width of the cause code field.
- XLEN, 32: data/PC width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- ex_req  in  1  synchronous exception from pipeline (level, held until flush)
- ex_cause  in  CAUSE_W  exception cause code
- ex_pc  in  XLEN  PC of faulting instruction
- ex_tval  in  XLEN  trap value
- irq_pending  in  1  an enabled interrupt is pending
- irq_cause  in  CAUSE_W  highest-priority pending interrupt code
- irq_pc  in  XLEN  PC of oldest uncommitted instruction
- mie_in  in  1  current mstatus.MIE
- mpie_in  in  1  current mstatus.MPIE
- mret_req  in  1  mret reached commit stage
- pipe_clear  in  1  pipeline drained (held while flush_req high)
- flush_req  out  1  request pipeline flush/drain
- intr  out  1  trap-commit strobe
- mret  out  1  return strobe
- mepc_wen / mepc_wdata  out  1 / XLEN
- mcause_wen  out  1
- mcause_int  out  1  mcause interrupt bit
- mcause_code  out  CAUSE_W
- mtval_wen / mtval_wdata  out  1 / XLEN
- mstatus_wen  out  1
- mie_next / mpie_next  out  1 / 1
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; every output 0; latched cause/pc/tval/int-bit cleared. RST asserted mid-sequence aborts immediately to IDLE; no CSR write occurs.
- States: IDLE, DRAIN, COMMIT, RET.
- IDLE arbitration, priority exception > interrupt > mret:
  - ex_req → latch ex_cause, ex_pc, ex_tval, int=0 → DRAIN.
  - else irq_pending & mie_in → latch irq_cause, irq_pc, tval=0, int=1 → DRAIN.
  - else mret_req → RET.
  - An irq_pending that is masked (mie_in=0) is never taken.
- DRAIN:
  - flush_req=1.
  - Inputs ignored (ex_req, irq_pending, mret_req) and latched values frozen; irq_pending deasserting does not cancel the trap.
  - Stay until pipe_clear=1, then → COMMIT. A pipe_clear already high on DRAIN entry still costs one DRAIN cycle.
- COMMIT (exactly one cycle):
  - flush_req=1, intr=1, all *_wen=1.
  - mepc_wdata = latched pc with bits[1:0] forced to 0.
  - mcause_int / mcause_code = latched values.
  - mtval_wdata = latched tval.
  - mie_next=0, mpie_next=mie_in.
  - → IDLE.
- RET (exactly one cycle):
  - mret=1, mstatus_wen=1, mie_next=mpie_in, mpie_next=1.
  - No flush_req; mepc/mcause/mtval not written.
  - → IDLE.
- Outputs are Moore-decoded from state and latches: no combinational path from inputs to strobes, except mie_next/mpie_next, which sample mie_in/mpie_in in COMMIT/RET.
- Latency:
  - exception/interrupt → intr ≥ 2 cycles after request sampled: IDLE → DRAIN ≥1 cycle → COMMIT.
  - mret_req → mret: 1 cycle.
- Back-to-back: requests are evaluated again in the first IDLE cycle after COMMIT/RET; no idle bubble is required beyond that cycle.
- Simultaneous events:
  - ex_req + irq_pending: exception taken; interrupt stays pending and is re-evaluated afterwards.
  - irq + mret_req with mie_in=1: interrupt taken; mret is flushed by the pipeline.
- The cause field occupies bits CAUSE_W-1:0; the consumer zero-extends it.

Test Plan:
- Reset mid-DRAIN: ex_req, ex_cause=2, ex_pc=0x100, tval=0xDEAD; assert RST in DRAIN → no wen ever seen; all outputs 0; busy=0.
- Exception, pipe_clear after 3 DRAIN cycles: ex_req, cause=2, ex_pc=0x1000, tval=0xDEADBEEF, mie_in=1 → flush_req high 4 cycles; COMMIT pulse with intr=1, mepc=0x1000, mcause_int=0, code=2, mtval=0xDEADBEEF, mie_next=0, mpie_next=1.
- Interrupt with irq_pending dropped during DRAIN: irq_pending, irq_cause=7, irq_pc=0x2004, mie_in=1 → trap still commits with mcause_int=1, code=7, mepc=0x2004, mtval=0.
- Masked interrupt: irq_pending=1, mie_in=0 for 10 cycles → busy=0, flush_req=0 throughout.
- mret: mret_req, mpie_in=1, mie_in=0 → next cycle mret=1, mie_next=1, mpie_next=1, mstatus_wen=1, flush_req=0; other wen=0.
- Simultaneous ex_req(cause 11) + irq_pending(cause 3) + mret_req → exception committed (code 11, int=0); interrupt then taken in the next sequence once mie_in is restored to 1.
